// File: rtl/mem_arbiter_cache_if.sv
// Requester and RAM-side bus of mem_arbiter_cache, bundled for port connection.
// Requesters hold *_req (with its address/data) until the matching one-cycle *_ready pulse.
interface mem_arbiter_cache_if #(parameter int ADDR_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_ready;
  logic [31:0]       if_inst;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [1:0]        ls_len;
  logic [31:0]       ls_wdata;
  logic              ls_ready;
  logic [31:0]       ls_rdata;
  logic              busy;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic [2:0]        dbg_state;

  modport slave (
    input  if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_len, ls_wdata, mem_din,
    output if_ready, if_inst, ls_ready, ls_rdata, busy, mem_dout, mem_a, mem_wr, dbg_state
  );

  modport master (
    output if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_len, ls_wdata, mem_din,
    input  if_ready, if_inst, ls_ready, ls_rdata, busy, mem_dout, mem_a, mem_wr, dbg_state
  );
endinterface

// File: rtl/mem_arbiter_cache.sv
// Byte-serial RAM arbiter for fetch (IF) and load/store (LS) requesters,
// with a direct-mapped, store-coherent instruction cache of one-word lines.
module mem_arbiter_cache #(
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 8,
  parameter int ICACHE_EN = 1
) (
  input logic clk,
  input logic rst,
  mem_arbiter_cache_if.slave bus
);
  localparam int LINES    = 1 << IDX_W;
  localparam int TAG_W    = ADDR_W - IDX_W - 2;
  localparam bit CACHE_ON = (ICACHE_EN != 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LS_RD = 3'd1,
    LS_WR = 3'd2,
    IF_RD = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic              own_if_q, own_if_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       line_mem [LINES];

  logic [IDX_W-1:0]  if_idx, ls_idx, fill_idx;
  logic              if_hit, ls_tag_hit, fill_en;
  logic [2:0]        ls_n;
  logic [7:0]        wbyte;

  assign if_idx     = bus.if_addr[IDX_W+1:2];
  assign ls_idx     = bus.ls_addr[IDX_W+1:2];
  assign fill_idx   = addr_q[IDX_W+1:2];
  assign if_hit     = CACHE_ON && valid_q[if_idx] &&
                      (tag_mem[if_idx] == bus.if_addr[ADDR_W-1:IDX_W+2]);
  assign ls_tag_hit = valid_q[ls_idx] && (tag_mem[ls_idx] == bus.ls_addr[ADDR_W-1:IDX_W+2]);
  assign ls_n       = bus.ls_len[1] ? 3'd4 : (bus.ls_len[0] ? 3'd2 : 3'd1);

  always_comb begin
    wbyte = 8'h00;
    case (cnt_q[1:0])
      2'd0: wbyte = wdata_q[7:0];
      2'd1: wbyte = wdata_q[15:8];
      2'd2: wbyte = wdata_q[23:16];
      2'd3: wbyte = wdata_q[31:24];
      default: wbyte = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    own_if_d = own_if_q;
    valid_d  = valid_q;
    fill_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ls_req) begin
          addr_d   = bus.ls_addr;
          n_d      = ls_n;
          wdata_d  = bus.ls_wdata;
          data_d   = '0;
          cnt_d    = '0;
          own_if_d = 1'b0;
          state_d  = bus.ls_we ? LS_WR : LS_RD;
          // A store makes any cached copy of its word stale.
          if (bus.ls_we && ls_tag_hit) valid_d[ls_idx] = 1'b0;
        end else if (bus.if_req && !bus.if_flush) begin
          addr_d   = bus.if_addr;
          n_d      = 3'd4;
          wdata_d  = '0;
          cnt_d    = '0;
          own_if_d = 1'b1;
          if (if_hit) begin
            data_d  = line_mem[if_idx];
            state_d = DONE;
          end else begin
            data_d  = '0;
            state_d = IF_RD;
          end
        end
      end
      LS_RD, IF_RD: begin
        // mem_din answers the address driven one cycle earlier.
        case (cnt_q)
          3'd1: data_d[7:0]   = bus.mem_din;
          3'd2: data_d[15:8]  = bus.mem_din;
          3'd3: data_d[23:16] = bus.mem_din;
          3'd4: data_d[31:24] = bus.mem_din;
          default: ;
        endcase
        if (cnt_q == n_q) state_d = DONE;
        else              cnt_d   = cnt_q + 3'd1;
        if (state_q == IF_RD && bus.if_flush) state_d = IDLE;
      end
      LS_WR: begin
        if (cnt_q == n_q - 3'd1) state_d = DONE;
        else                     cnt_d   = cnt_q + 3'd1;
      end
      DONE: begin
        state_d = IDLE;
        // Refilling after a hit rewrites identical contents, so no miss flag is kept.
        fill_en = CACHE_ON && own_if_q && !bus.if_flush && !rst;
        if (fill_en) valid_d[fill_idx] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      own_if_q <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      own_if_q <= own_if_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= addr_q[ADDR_W-1:IDX_W+2];
      line_mem[fill_idx] <= data_q;
    end
  end

  always_comb begin
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    if ((state_q == LS_RD || state_q == IF_RD || state_q == LS_WR) && cnt_q < n_q) begin
      bus.mem_a = addr_q + ADDR_W'(cnt_q);
      if (state_q == LS_WR) begin
        bus.mem_dout = wbyte;
        bus.mem_wr   = 1'b1;
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.if_ready  = (state_q == DONE) && own_if_q && !bus.if_flush;
  assign bus.ls_ready  = (state_q == DONE) && !own_if_q;
  assign bus.if_inst   = bus.if_ready ? data_q : '0;
  assign bus.ls_rdata  = bus.ls_ready ? data_q : '0;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mem_arbiter_cache.sv
// Randomized and directed bench for mem_arbiter_cache against a byte-array
// memory model and a word-address cache model.
module tb_mem_arbiter_cache;
  logic clk;
  logic rst;

  mem_arbiter_cache_if #(.ADDR_W(32)) bus ();

  mem_arbiter_cache #(.ADDR_W(32), .IDX_W(8), .ICACHE_EN(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram     [0:8191];
  logic [7:0] ref_mem [0:8191];

  // RAM responder: registered read, write strobe on the same edge.
  always @(posedge clk) begin : ram_model
    logic [7:0] rd;
    rd = ram[bus.mem_a[12:0]];
    if (bus.mem_wr) ram[bus.mem_a[12:0]] = bus.mem_dout;
    bus.mem_din <= rd;
  end

  int checks;
  int failures;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    logic        busy;
    logic        ifr;
    logic        lsr;
    logic [31:0] ifi;
    logic [31:0] lsd;
  } cyc_t;
  cyc_t log_q[$];

  // Cache model: line index -> word address held in that line.
  int unsigned cmodel [int];

  function automatic int n_of(input logic [1:0] len);
    return (len == 2'b00) ? 1 : ((len == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
    logic [31:0] v;
    logic [31:0] a;
    v = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      v[8*i +: 8] = ref_mem[a[12:0]];
    end
    return v;
  endfunction

  function automatic bit cache_hit(input logic [31:0] addr);
    int idx;
    idx = int'(addr[9:2]);
    return cmodel.exists(idx) && (cmodel[idx] == 32'(addr[31:2]));
  endfunction

  task automatic cache_fill(input logic [31:0] addr);
    cmodel[int'(addr[9:2])] = 32'(addr[31:2]);
  endtask

  task automatic ref_store(input logic [31:0] addr, input int n, input logic [31:0] wd);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      ref_mem[a[12:0]] = wd[8*i +: 8];
    end
    if (cache_hit(addr)) cmodel.delete(int'(addr[9:2]));
  endtask

  // Expected {mem_a, mem_wr, mem_dout} in cycle k (k >= 1) of a transfer.
  function automatic logic [40:0] exp_bus(input bit is_store, input int k, input int nact,
                                          input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    a = '0; wr = 1'b0; d = '0;
    if (k <= nact) begin
      a = addr + 32'(k - 1);
      if (is_store) begin
        wr = 1'b1;
        d  = wd[8*(k-1) +: 8];
      end
    end
    return {a, wr, d};
  endfunction

  // Starts at cycle c0 (DUT idle); returns the cycle index of ready or -1.
  task automatic xfer(input bit is_if, input bit we, input logic [31:0] addr,
                      input logic [1:0] len, input logic [31:0] wd,
                      input int flush_at, input int rst_at, input int max_cyc,
                      output logic [31:0] data, output int ready_cyc);
    bit got;
    log_q.delete();
    data = '0;
    ready_cyc = -1;
    if (is_if) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_addr = addr; bus.ls_len = len; bus.ls_wdata = wd;
    end
    for (int k = 0; k <= max_cyc; k++) begin
      if (k == flush_at) begin bus.if_flush = 1'b1; bus.if_req = 1'b0; end
      if (k == rst_at)   begin rst = 1'b1; bus.if_req = 1'b0; bus.ls_req = 1'b0; end
      @(negedge clk);
      if (k > 0)
        log_q.push_back('{bus.mem_a, bus.mem_wr, bus.mem_dout, bus.busy,
                          bus.if_ready, bus.ls_ready, bus.if_inst, bus.ls_rdata});
      got = is_if ? bus.if_ready : bus.ls_ready;
      if (got && ready_cyc < 0) begin
        ready_cyc = k;
        data = is_if ? bus.if_inst : bus.ls_rdata;
      end
      @(posedge clk); #1;
      bus.if_flush = 1'b0;
      rst = 1'b0;
      if (got) break;
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if ({bus.if_ready, bus.ls_ready, bus.if_inst, bus.ls_rdata} !== 66'd0) begin
      failures++;
      $display("FAIL reset_ready_data got=%b/%b/%h/%h exp=0", bus.if_ready, bus.ls_ready,
               bus.if_inst, bus.ls_rdata);
    end
    checks++;
    if ({bus.mem_a, bus.mem_wr, bus.mem_dout} !== 41'd0) begin
      failures++;
      $display("FAIL reset_mem_bus got=%h/%b/%h exp=0", bus.mem_a, bus.mem_wr, bus.mem_dout);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cmodel.delete();
  endtask

  task automatic test_fetch_miss_hit();
    logic [31:0] d;
    int rc;
    bit bad;
    xfer(1'b1, 1'b0, 32'h100, 2'b10, '0, -1, -1, 20, d, rc);
    checks++;
    if (rc !== 6 || d !== 32'h0000_0513) begin
      failures++; $display("FAIL fetch_miss got=c%0d/%h exp=c6/00000513", rc, d);
    end
    bad = 1'b0;
    foreach (log_q[i])
      if ({log_q[i].a, log_q[i].wr, log_q[i].d} !== exp_bus(1'b0, i + 1, 4, 32'h100, '0)) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++; $display("FAIL fetch_miss_bus got=%h exp=addresses 100..103 in c1..c4", log_q[0].a);
    end
    cache_fill(32'h100);
    xfer(1'b1, 1'b0, 32'h100, 2'b10, '0, -1, -1, 20, d, rc);
    checks++;
    if (rc !== 1 || d !== 32'h0000_0513 || log_q[0].a !== 32'h0 || log_q[0].wr !== 1'b0) begin
      failures++;
      $display("FAIL fetch_hit got=c%0d/%h mem_a=%h exp=c1/00000513 mem_a=0", rc, d, log_q[0].a);
    end
  endtask

  task automatic test_store_load_half();
    logic [31:0] d;
    int rc;
    xfer(1'b0, 1'b1, 32'h1002, 2'b01, 32'hAABB_CCDD, -1, -1, 20, d, rc);
    checks++;
    if (rc !== 3) begin
      failures++; $display("FAIL store_half_latency got=c%0d exp=c3", rc);
    end
    checks++;
    if ({log_q[0].a, log_q[0].wr, log_q[0].d} !== {32'h1002, 1'b1, 8'hDD} ||
        {log_q[1].a, log_q[1].wr, log_q[1].d} !== {32'h1003, 1'b1, 8'hCC}) begin
      failures++;
      $display("FAIL store_half_bus got=%h/%b/%h %h/%b/%h exp=1002/1/dd 1003/1/cc",
               log_q[0].a, log_q[0].wr, log_q[0].d, log_q[1].a, log_q[1].wr, log_q[1].d);
    end
    ref_store(32'h1002, 2, 32'hAABB_CCDD);
    xfer(1'b0, 1'b0, 32'h1002, 2'b01, '0, -1, -1, 20, d, rc);
    checks++;
    if (rc !== 4 || d !== 32'h0000_CCDD) begin
      failures++; $display("FAIL load_half got=c%0d/%h exp=c4/0000ccdd", rc, d);
    end
  endtask

  task automatic test_store_invalidate();
    logic [31:0] d;
    int rc;
    xfer(1'b1, 1'b0, 32'h100, 2'b10, '0, -1, -1, 20, d, rc);
    checks++;
    if (rc !== 1) begin
      failures++; $display("FAIL inval_prehit got=c%0d exp=c1", rc);
    end
    xfer(1'b0, 1'b1, 32'h100, 2'b10, 32'h0, -1, -1, 20, d, rc);
    checks++;
    if (rc !== 5) begin
      failures++; $display("FAIL inval_store got=c%0d exp=c5", rc);
    end
    ref_store(32'h100, 4, 32'h0);
    xfer(1'b1, 1'b0, 32'h100, 2'b10, '0, -1, -1, 20, d, rc);
    checks++;
    if (rc !== 6 || d !== 32'h0) begin
      failures++; $display("FAIL inval_refetch got=c%0d/%h exp=c6/00000000", rc, d);
    end
    cache_fill(32'h100);
  endtask

  task automatic test_priority();
    int ls_c, if_c;
    logic [31:0] ls_d, if_d;
    ls_c = -1; if_c = -1; ls_d = '0; if_d = '0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h1000; bus.ls_len = 2'b10;
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (bus.ls_ready && ls_c < 0) begin ls_c = k; ls_d = bus.ls_rdata; end
      if (bus.if_ready && if_c < 0) begin if_c = k; if_d = bus.if_inst; end
      @(posedge clk); #1;
      if (ls_c == k) bus.ls_req = 1'b0;
      if (if_c == k) break;
    end
    bus.ls_req = 1'b0; bus.if_req = 1'b0;
    checks++;
    if (ls_c !== 6 || ls_d !== ref_read(32'h1000, 4)) begin
      failures++; $display("FAIL prio_ls got=c%0d/%h exp=c6/%h", ls_c, ls_d, ref_read(32'h1000, 4));
    end
    checks++;
    if (if_c !== 13 || if_d !== ref_read(32'h300, 4)) begin
      failures++; $display("FAIL prio_if got=c%0d/%h exp=c13/%h", if_c, if_d, ref_read(32'h300, 4));
    end
    cache_fill(32'h300);
  endtask

  task automatic test_back_to_back();
    int r1, r2;
    logic [31:0] d1, d2;
    r1 = -1; r2 = -1; d1 = '0; d2 = '0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h1002; bus.ls_len = 2'b01;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (bus.ls_ready) begin
        if (r1 < 0) begin r1 = k; d1 = bus.ls_rdata; end
        else begin r2 = k; d2 = bus.ls_rdata; end
      end
      @(posedge clk); #1;
      if (r2 >= 0) break;
    end
    bus.ls_req = 1'b0;
    checks++;
    if (r1 !== 4 || r2 !== 9 || d1 !== ref_read(32'h1002, 2) || d2 !== ref_read(32'h1002, 2)) begin
      failures++;
      $display("FAIL back_to_back got=c%0d/%h c%0d/%h exp=c4 c9 data %h", r1, d1, r2, d2,
               ref_read(32'h1002, 2));
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int rc;
    xfer(1'b1, 1'b0, 32'h200, 2'b10, '0, 3, -1, 10, d, rc);
    checks++;
    if (rc !== -1 || log_q[3].busy !== 1'b0) begin
      failures++; $display("FAIL flush_abort got=ready c%0d busy_c4=%b exp=none busy_c4=0", rc, log_q[3].busy);
    end
    xfer(1'b1, 1'b0, 32'h200, 2'b10, '0, -1, -1, 20, d, rc);
    checks++;
    if (rc !== 6 || d !== ref_read(32'h200, 4)) begin
      failures++; $display("FAIL flush_nofill got=c%0d/%h exp=c6/%h", rc, d, ref_read(32'h200, 4));
    end
    cache_fill(32'h200);
    xfer(1'b0, 1'b0, 32'h1000, 2'b10, '0, 2, -1, 20, d, rc);
    checks++;
    if (rc !== 6 || d !== ref_read(32'h1000, 4)) begin
      failures++; $display("FAIL flush_ls_unaffected got=c%0d/%h exp=c6/%h", rc, d, ref_read(32'h1000, 4));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int rc;
    xfer(1'b0, 1'b0, 32'h1000, 2'b10, '0, -1, 2, 12, d, rc);
    checks++;
    if (rc !== -1) begin
      failures++; $display("FAIL rst_mid_ready got=c%0d exp=none", rc);
    end
    checks++;
    if ({log_q[2].a, log_q[2].wr, log_q[2].d, log_q[2].busy, log_q[2].ifr, log_q[2].lsr,
         log_q[2].ifi, log_q[2].lsd} !== 108'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=a%h wr%b d%h busy%b exp=all 0", log_q[2].a, log_q[2].wr,
               log_q[2].d, log_q[2].busy);
    end
    cmodel.delete();
    xfer(1'b1, 1'b0, 32'h200, 2'b10, '0, -1, -1, 20, d, rc);
    checks++;
    if (rc !== 6 || d !== ref_read(32'h200, 4)) begin
      failures++; $display("FAIL rst_mid_refetch got=c%0d/%h exp=c6/%h", rc, d, ref_read(32'h200, 4));
    end
    cache_fill(32'h200);
  endtask

  task automatic test_random();
    int kind, n, nact, exp_lat, rc;
    bit hit, bad;
    logic [1:0]  len;
    logic [31:0] addr, wd, d, exp_d;
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 2));
      len  = 2'($urandom_range(0, 3));
      wd   = $urandom;
      addr = 32'h100 + 32'($urandom_range(0, 1)) * 32'h400;
      if (kind == 2) begin
        len  = 2'b10;
        addr = addr + 32'($urandom_range(0, 7)) * 32'd4;
      end else begin
        addr = addr + 32'($urandom_range(0, 31));
      end
      n    = n_of(len);
      addr = addr & ~(32'(n) - 32'd1);
      hit  = (kind == 2) && cache_hit(addr);
      nact = (kind == 2) ? (hit ? 0 : 4) : n;
      exp_lat = (kind == 0) ? n + 2 : ((kind == 1) ? n + 1 : (hit ? 1 : 6));
      exp_d   = (kind == 1) ? 32'h0 : ref_read(addr, n);
      xfer(kind == 2, kind == 1, addr, len, wd, -1, -1, 12, d, rc);
      checks++;
      if (rc !== exp_lat) begin
        failures++; $display("FAIL rand_latency op=%0d addr=%h got=c%0d exp=c%0d", kind, addr, rc, exp_lat);
      end
      if (kind != 1) begin
        checks++;
        if (d !== exp_d) begin
          failures++; $display("FAIL rand_data op=%0d addr=%h len=%0d got=%h exp=%h", kind, addr, n, d, exp_d);
        end
      end
      bad = 1'b0;
      foreach (log_q[j])
        if ({log_q[j].a, log_q[j].wr, log_q[j].d} !== exp_bus(kind == 1, j + 1, nact, addr, wd)) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++; $display("FAIL rand_bus op=%0d addr=%h c1_got=%h/%b/%h", kind, addr,
                             log_q[0].a, log_q[0].wr, log_q[0].d);
      end
      if (kind == 1) ref_store(addr, n, wd);
      if (kind == 2) cache_fill(addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_len = '0; bus.ls_wdata = '0;
    for (int i = 0; i < 8192; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      ref_mem[i] = b;
    end
    ram[13'h100] = 8'h13; ram[13'h101] = 8'h05; ram[13'h102] = 8'h00; ram[13'h103] = 8'h00;
    ref_mem[13'h100] = 8'h13; ref_mem[13'h101] = 8'h05;
    ref_mem[13'h102] = 8'h00; ref_mem[13'h103] = 8'h00;
    test_reset();
    test_fetch_miss_hit();
    test_store_load_half();
    test_store_invalidate();
    test_priority();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
